// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: controller states,
// the hardwired zero register and the default MDU latency.
package pipe_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MDU_BUSY = 1'b1} ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MDU_LAT_DEFAULT = 8;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for the stall and other perf counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use stalls, taken-branch squashes resolved in MEM,
// and multi-cycle MDU front-end stalls, with a saturating count of stalled cycles.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             ex_mdu_start_i,
  input  logic             mem_branch_taken_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             id_ex_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic             mdu_kill_o,
  output logic             mdu_done_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output ctrl_state_t      dbg_state_o
);
  // The start cycle and the done cycle are both stall cycles, hence the -2.
  localparam logic [7:0] BUSY_INIT = 8'(MDU_LAT - 2);

  ctrl_state_t state_q, state_d;
  logic [7:0]  busy_cnt_q, busy_cnt_d;
  logic        load_use;

  assign load_use = ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  always_comb begin
    state_d        = state_q;
    busy_cnt_d     = busy_cnt_q;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    mdu_kill_o     = 1'b0;
    mdu_done_o     = 1'b0;
    if (rst_i) begin
      case (state_q)
        RUN: begin
          if (mem_branch_taken_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
          end else if (ex_mdu_start_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_flush_o = 1'b1;
            state_d        = MDU_BUSY;
            busy_cnt_d     = BUSY_INIT;
          end else if (load_use) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_flush_o  = 1'b1;
          end
        end
        MDU_BUSY: begin
          ex_mem_flush_o = 1'b1;
          if (mem_branch_taken_i) begin
            // An older branch squashes the MDU op and everything behind it.
            mdu_kill_o    = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            state_d       = RUN;
            busy_cnt_d    = 8'd0;
          end else begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_write_o = 1'b0;
            if (busy_cnt_q == 8'd0) begin
              mdu_done_o = 1'b1;
              state_d    = RUN;
            end else begin
              busy_cnt_d = busy_cnt_q - 8'd1;
            end
          end
        end
        default: begin
          state_d    = RUN;
          busy_cnt_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      busy_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (!pc_write_o),
    .clr_i   (1'b0),
    .count_o (stall_cnt_o)
  );

  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_hazard_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MDU_LAT = 8;
  localparam int CNT_W   = 16;
  localparam int CNT_W4  = 4;
  localparam logic [7:0] OUT_DEF  = 8'b1110_0000;
  localparam logic [7:0] OUT_LU   = 8'b0010_1000;
  localparam logic [7:0] OUT_MDU  = 8'b0000_0100;
  localparam logic [7:0] OUT_DONE = 8'b0000_0101;
  localparam logic [7:0] OUT_BR   = 8'b1111_1100;
  localparam logic [7:0] OUT_KILL = 8'b1111_1110;

  // clock / reset
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs_i = '0, id_rt_i = '0, ex_rt_i = '0;
  logic id_uses_rt_i = 1'b0, ex_mem_read_i = 1'b0, ex_mdu_start_i = 1'b0, mem_branch_taken_i = 1'b0;

  logic pc_write_o, if_id_write_o, id_ex_write_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
  logic mdu_kill_o, mdu_done_o;
  logic [CNT_W-1:0] stall_cnt_o;
  ctrl_state_t dbg_state_o;

  logic pc4, ifw4, idw4, iff4, idf4, emf4, kill4, done4;
  logic [CNT_W4-1:0] stall_cnt4_o;
  ctrl_state_t dbg_state4_o;

  hazard_stall_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_rt_i(ex_rt_i), .ex_mdu_start_i(ex_mdu_start_i),
    .mem_branch_taken_i(mem_branch_taken_i), .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o),
    .id_ex_write_o(id_ex_write_o), .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
    .ex_mem_flush_o(ex_mem_flush_o), .mdu_kill_o(mdu_kill_o), .mdu_done_o(mdu_done_o),
    .stall_cnt_o(stall_cnt_o), .dbg_state_o(dbg_state_o)
  );

  hazard_stall_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_rt_i(ex_rt_i), .ex_mdu_start_i(ex_mdu_start_i),
    .mem_branch_taken_i(mem_branch_taken_i), .pc_write_o(pc4), .if_id_write_o(ifw4),
    .id_ex_write_o(idw4), .if_id_flush_o(iff4), .id_ex_flush_o(idf4),
    .ex_mem_flush_o(emf4), .mdu_kill_o(kill4), .mdu_done_o(done4),
    .stall_cnt_o(stall_cnt4_o), .dbg_state_o(dbg_state4_o)
  );

  wire [7:0] obs_now  = {pc_write_o, if_id_write_o, id_ex_write_o, if_id_flush_o,
                         id_ex_flush_o, ex_mem_flush_o, mdu_kill_o, mdu_done_o};
  wire [7:0] obs4_now = {pc4, ifw4, idw4, iff4, idf4, emf4, kill4, done4};

  // reference model: rem = MDU stall cycles still to come, counting the current one
  int rem = 0;
  int exp_cnt = 0;
  int exp_cnt4 = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  logic [7:0] obs, obs4, exp_o;
  logic [CNT_W-1:0] cnt_obs, cnt_exp;
  logic [CNT_W4-1:0] cnt4_obs, cnt4_exp;
  ctrl_state_t st_obs, st4_obs, st_exp;

  function automatic logic model_load_use();
    return ex_mem_read_i && (ex_rt_i != 5'd0) &&
           ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
  endfunction

  function automatic logic [7:0] model_outs();
    if (!rst_i) return OUT_DEF;
    if (rem > 0) begin
      if (mem_branch_taken_i) return OUT_KILL;
      return (rem == 1) ? OUT_DONE : OUT_MDU;
    end
    if (mem_branch_taken_i) return OUT_BR;
    if (ex_mdu_start_i) return OUT_MDU;
    if (model_load_use()) return OUT_LU;
    return OUT_DEF;
  endfunction

  // driver tasks
  task automatic drive(input logic rd, input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses, input logic mdu, input logic br);
    ex_mem_read_i = rd; ex_rt_i = ert; id_rs_i = rs; id_rt_i = rt;
    id_uses_rt_i = uses; ex_mdu_start_i = mdu; mem_branch_taken_i = br;
  endtask

  // Samples everything at the falling edge, then advances the model across the rising edge.
  task automatic run_cycle();
    @(negedge clk);
    obs = obs_now; obs4 = obs4_now; exp_o = model_outs();
    cnt_obs = stall_cnt_o; cnt4_obs = stall_cnt4_o;
    cnt_exp = CNT_W'(exp_cnt); cnt4_exp = CNT_W4'(exp_cnt4);
    st_obs = dbg_state_o; st4_obs = dbg_state4_o;
    st_exp = (rem > 0) ? MDU_BUSY : RUN;
    @(posedge clk);
    if (rst_i) begin
      if (!exp_o[7]) begin
        if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        if (exp_cnt4 < (1 << CNT_W4) - 1) exp_cnt4++;
      end
      if (rem > 0) rem = mem_branch_taken_i ? 0 : rem - 1;
      else if (!mem_branch_taken_i && ex_mdu_start_i) rem = MDU_LAT - 1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    run_cycle();
    n_checks++;
    if (obs !== OUT_DEF) begin n_fail++; $display("FAIL reset_outs: got %b want %b", obs, OUT_DEF); end
    n_checks++;
    if (cnt_obs !== '0 || cnt4_obs !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt_obs, cnt4_obs);
    end
    n_checks++;
    if (st_obs !== RUN) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", st_obs, RUN); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    run_cycle();
    n_checks++;
    if (obs !== OUT_DEF) begin n_fail++; $display("FAIL reset_idle: got %b want %b", obs, OUT_DEF); end
  endtask

  task automatic test_load_use();
    logic [CNT_W-1:0] c0;
    drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
    run_cycle();
    c0 = cnt_obs;
    n_checks++;
    if (obs !== OUT_LU || exp_o !== OUT_LU) begin
      n_fail++; $display("FAIL load_use_stall: got %b want %b", obs, OUT_LU);
    end
    drive(1'b0, 5'd0, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0);
    run_cycle();
    n_checks++;
    if (obs !== OUT_DEF) begin n_fail++; $display("FAIL load_use_release: got %b want %b", obs, OUT_DEF); end
    n_checks++;
    if (cnt_obs !== c0 + 1'b1 || cnt_obs !== cnt_exp) begin
      n_fail++; $display("FAIL load_use_cnt: got %0d want %0d", cnt_obs, c0 + 1'b1);
    end
    // rt-only match counts only when the ID instruction reads rt
    drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
    run_cycle();
    n_checks++;
    if (obs !== OUT_LU) begin n_fail++; $display("FAIL load_use_rt: got %b want %b", obs, OUT_LU); end
    drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
    run_cycle();
    n_checks++;
    if (obs !== OUT_DEF) begin n_fail++; $display("FAIL load_use_rt_unused: got %b want %b", obs, OUT_DEF); end
  endtask

  task automatic test_load_zero();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    run_cycle();
    n_checks++;
    if (obs !== OUT_DEF) begin n_fail++; $display("FAIL load_zero: got %b want %b", obs, OUT_DEF); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mdu();
    logic [CNT_W-1:0] c0;
    logic [7:0] want;
    for (int i = 0; i <= MDU_LAT; i++)
      exp_q.push_back((i == MDU_LAT) ? OUT_DEF : ((i == MDU_LAT - 1) ? OUT_DONE : OUT_MDU));
    c0 = '0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i <= MDU_LAT; i++) begin
      run_cycle();
      if (i == 0) c0 = cnt_obs;
      // a load-use in the middle of the MDU stall must be ignored
      if (i == 1) drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
      else drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      want = exp_q.pop_front();
      n_checks++;
      if (obs !== want || exp_o !== want) begin
        n_fail++; $display("FAIL mdu_cycle_%0d: got %b want %b", i, obs, want);
      end
    end
    n_checks++;
    if (cnt_obs !== c0 + CNT_W'(MDU_LAT)) begin
      n_fail++; $display("FAIL mdu_cnt: got %0d want %0d", cnt_obs, c0 + CNT_W'(MDU_LAT));
    end
  endtask

  task automatic test_branch_in_mdu();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i <= 4; i++) begin
      run_cycle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, i == 2);
      n_checks++;
      if (obs !== exp_o || obs[0] !== 1'b0) begin
        n_fail++; $display("FAIL branch_mdu_cycle_%0d: got %b want %b", i, obs, exp_o);
      end
      if (i == 3) begin
        n_checks++;
        if (obs !== OUT_KILL) begin n_fail++; $display("FAIL branch_mdu_kill: got %b want %b", obs, OUT_KILL); end
      end
      if (i == 4) begin
        n_checks++;
        if (obs !== OUT_DEF || st_obs !== RUN) begin
          n_fail++; $display("FAIL branch_mdu_resume: got %b/%0d want %b/%0d", obs, st_obs, OUT_DEF, RUN);
        end
      end
    end
  endtask

  task automatic test_branch_vs_load_use();
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1);
    run_cycle();
    n_checks++;
    if (obs !== OUT_BR) begin n_fail++; $display("FAIL branch_vs_lu: got %b want %b", obs, OUT_BR); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    run_cycle();
    n_checks++;
    if (obs !== OUT_BR) begin n_fail++; $display("FAIL branch_vs_mdu: got %b want %b", obs, OUT_BR); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    run_cycle();
    n_checks++;
    if (obs !== OUT_DEF || st_obs !== RUN) begin
      n_fail++; $display("FAIL branch_vs_mdu_after: got %b/%0d want %b/%0d", obs, st_obs, OUT_DEF, RUN);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    run_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    run_cycle();
    #2;
    rst_i = 1'b0;
    rem = 0; exp_cnt = 0; exp_cnt4 = 0;
    #1;
    n_checks++;
    if (obs_now !== OUT_DEF) begin n_fail++; $display("FAIL reset_mid_outs: got %b want %b", obs_now, OUT_DEF); end
    n_checks++;
    if (stall_cnt_o !== '0 || stall_cnt4_o !== '0 || dbg_state_o !== RUN) begin
      n_fail++; $display("FAIL reset_mid_state: got cnt %0d state %0d want 0/%0d", stall_cnt_o, dbg_state_o, RUN);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    run_cycle();
    n_checks++;
    if (obs !== OUT_DEF || cnt_obs !== '0) begin
      n_fail++; $display("FAIL reset_mid_after: got %b cnt %0d want %b cnt 0", obs, cnt_obs, OUT_DEF);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
      run_cycle();
      n_checks++;
      if (obs4 !== OUT_LU || cnt4_obs !== cnt4_exp) begin
        n_fail++; $display("FAIL sat_step_%0d: got %b cnt %0d want %b cnt %0d", i, obs4, cnt4_obs, OUT_LU, cnt4_exp);
      end
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    run_cycle();
    n_checks++;
    if (cnt4_obs !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", cnt4_obs); end
    n_checks++;
    if (cnt_obs !== 16'd20) begin n_fail++; $display("FAIL sat_wide: got %0d want 20", cnt_obs); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
      run_cycle();
      n_checks++;
      if (obs !== exp_o || obs4 !== exp_o) begin
        n_fail++; $display("FAIL rand_outs_%0d: got %b/%b want %b", i, obs, obs4, exp_o);
      end
      n_checks++;
      if (cnt_obs !== cnt_exp || cnt4_obs !== cnt4_exp) begin
        n_fail++; $display("FAIL rand_cnt_%0d: got %0d/%0d want %0d/%0d", i, cnt_obs, cnt4_obs, cnt_exp, cnt4_exp);
      end
      n_checks++;
      if (st_obs !== st_exp || st4_obs !== st_exp) begin
        n_fail++; $display("FAIL rand_state_%0d: got %0d want %0d", i, st_obs, st_exp);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_load_use();
    test_load_zero();
    test_mdu();
    test_branch_in_mdu();
    test_branch_vs_load_use();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
